alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Registered, multi-step successor to the combinational ALU control decoder, parametrised in opcode width, AluOp width and encodings.
- Accepts one decoded opcode per handshake and emits one or two ALU steps per instruction, each step being an ALU operation plus operand-source selects.
- Adds stall handling, post-increment and branch-target steps, stack-pointer arithmetic, and illegal-opcode flagging.
- Sits between the main multi-cycle control FSM and the 32-bit ALU and its operand muxes.

Parameters:
- OPW, 6, opcode width (>=5).
- AOPW, 2, alu_op width (>=2).
- OP_AND, 0, AND encoding on alu_op.
- OP_ADD, 1, ADD encoding.
- OP_SUB, 2, SUB encoding.
- OP_NOP, 3, no-operation encoding.
- BR_TARGET_ADD, 1, 1 = branches take a second step computing PC+imm; 0 = branches take one step.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  opcode valid; accepted when start && ready.
- opcode  in  OPW  opcode: AND=0, ADD=1, SUB=2, ANDI=3, ADDI=4, LW=5, LWPOI=6, SW=7, BGT=8, BLT=9, BEQ=10, BNE=11, JMP=12, CALL=13, RET=14, PUSH=15, POP=16.
- stall  in  1  freezes state and all outputs.
- ready  out  1  can accept an opcode this cycle.
- alu_valid  out  1  current step outputs are valid.
- alu_op  out  AOPW  ALU operation.
- src_a_sel  out  2  0 = RegA, 1 = PC, 2 = SP.
- src_b_sel  out  2  0 = RegB, 1 = imm, 2 = constant one.
- alu_step  out  1  step index, 0 or 1.
- alu_last  out  1  current step is the final step.
- illegal  out  1  unknown opcode, asserted on its single step.

Behaviour:
- Reset (synchronous, active-high, highest priority, also mid-sequence):
  - state=IDLE; ready=1; alu_valid=0; alu_op=OP_NOP; selects=0; alu_step=0; alu_last=0; illegal=0; latched opcode=0.
- States: IDLE, STEP0, STEP1.
  - IDLE: start accepted -> STEP0 next cycle; opcode latched.
  - STEP0: if the sequence has 2 steps -> STEP1, else -> IDLE (or STEP0 on back-to-back).
  - STEP1: -> IDLE (or STEP0 on back-to-back).
- All outputs are registered. Latency: start accepted at edge N -> step 0 is visible in the cycle after edge N.
- ready is combinational: (state==IDLE || alu_last) && !stall. Back-to-back issue is legal, with no bubble between instructions.
- stall=1: no transition, outputs held, ready=0, start ignored. Reset overrides stall.
- alu_valid=1 in STEP0 and STEP1, 0 in IDLE.
- Step sequences, written as op(a,b):
  - AND: AND(RegA,RegB).
  - ANDI: AND(RegA,imm).
  - ADD: ADD(RegA,RegB).
  - ADDI, LW, SW: ADD(RegA,imm).
  - SUB: SUB(RegA,RegB).
  - LWPOI: step0 ADD(RegA,imm); step1 ADD(RegA,one).
  - BGT, BLT, BEQ, BNE: step0 SUB(RegA,RegB); step1 ADD(PC,imm) only if BR_TARGET_ADD=1.
  - PUSH, CALL: SUB(SP,one).
  - POP, RET: ADD(SP,one).
  - JMP: NOP, selects 0.
  - Any other opcode: NOP, selects 0, illegal=1 for that step only.
- alu_last=1 on the final step of each sequence. alu_step=1 only in STEP1.
- The opcode input is sampled only on acceptance; changes afterwards have no effect.

Test Plan:
- Reset held 2 cycles, then released -> ready=1, alu_valid=0, alu_op=3, all selects 0.
- start with opcode=4 (ADDI) -> next cycle alu_valid=1, alu_op=1, src_a_sel=0, src_b_sel=1, alu_last=1; the cycle after, alu_valid=0.
- opcode=6 (LWPOI), with stall=1 asserted during STEP0 for 3 cycles -> STEP0 outputs (ADD, b=1) held 4 cycles, ready=0 throughout; then STEP1 shows ADD with src_b_sel=2, alu_step=1, alu_last=1.
- opcode=10 (BEQ), once with BR_TARGET_ADD=1 and once with 0:
  - BR_TARGET_ADD=1 -> SUB(0,0) then ADD with src_a_sel=1, src_b_sel=1.
  - BR_TARGET_ADD=0 -> single SUB step with alu_last=1.
- Back-to-back: opcode=15 (PUSH), then 16 (POP) on consecutive cycles, then 12 (JMP) -> SUB(SP,one), then ADD(SP,one), then NOP, with alu_valid=1 in three consecutive cycles and no bubble.
- opcode=63 -> one step with alu_op=3, illegal=1, alu_last=1; reset asserted during STEP0 of a LWPOI -> next cycle IDLE reset values, with no STEP1.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Issue/step bundle between the control FSM and the ALU op sequencer.
// Master drives opcodes and stall; slave returns ready and ALU step controls.
interface alu_op_sequencer_if #(
    parameter int OPW  = 6,
    parameter int AOPW = 2
);
    logic            start;
    logic [OPW-1:0]  opcode;
    logic            stall;
    logic            ready;
    logic            alu_valid;
    logic [AOPW-1:0] alu_op;
    logic [1:0]      src_a_sel;
    logic [1:0]      src_b_sel;
    logic            alu_step;
    logic            alu_last;
    logic            illegal;

    modport master (
        output start, opcode, stall,
        input  ready, alu_valid, alu_op, src_a_sel,
        input  src_b_sel, alu_step, alu_last, illegal
    );

    modport slave (
        input  start, opcode, stall,
        output ready, alu_valid, alu_op, src_a_sel,
        output src_b_sel, alu_step, alu_last, illegal
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Registered ALU op sequencer: one or two ALU steps per accepted opcode,
// with stall hold, branch-target and post-increment steps, illegal flagging.
module alu_op_sequencer #(
    parameter int          OPW           = 6,
    parameter int          AOPW          = 2,
    parameter int unsigned OP_AND        = 0,
    parameter int unsigned OP_ADD        = 1,
    parameter int unsigned OP_SUB        = 2,
    parameter int unsigned OP_NOP        = 3,
    parameter bit          BR_TARGET_ADD = 1'b1
) (
    input logic               clk,
    input logic               reset,
    alu_op_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, STEP0, STEP1} state_t;

    typedef struct packed {
        logic [AOPW-1:0] op;
        logic [1:0]      a;
        logic [1:0]      b;
        logic            last;
        logic            ill;
    } step_t;

    localparam logic [AOPW-1:0] A_AND = AOPW'(OP_AND);
    localparam logic [AOPW-1:0] A_ADD = AOPW'(OP_ADD);
    localparam logic [AOPW-1:0] A_SUB = AOPW'(OP_SUB);
    localparam logic [AOPW-1:0] A_NOP = AOPW'(OP_NOP);

    localparam logic [1:0] S_REG = 2'd0;
    localparam logic [1:0] S_PC  = 2'd1;
    localparam logic [1:0] S_SP  = 2'd2;
    localparam logic [1:0] S_IMM = 2'd1;
    localparam logic [1:0] S_ONE = 2'd2;

    localparam logic [OPW-1:0] OC_AND   = OPW'(0);
    localparam logic [OPW-1:0] OC_ADD   = OPW'(1);
    localparam logic [OPW-1:0] OC_SUB   = OPW'(2);
    localparam logic [OPW-1:0] OC_ANDI  = OPW'(3);
    localparam logic [OPW-1:0] OC_ADDI  = OPW'(4);
    localparam logic [OPW-1:0] OC_LW    = OPW'(5);
    localparam logic [OPW-1:0] OC_LWPOI = OPW'(6);
    localparam logic [OPW-1:0] OC_SW    = OPW'(7);
    localparam logic [OPW-1:0] OC_BGT   = OPW'(8);
    localparam logic [OPW-1:0] OC_BLT   = OPW'(9);
    localparam logic [OPW-1:0] OC_BEQ   = OPW'(10);
    localparam logic [OPW-1:0] OC_BNE   = OPW'(11);
    localparam logic [OPW-1:0] OC_JMP   = OPW'(12);
    localparam logic [OPW-1:0] OC_CALL  = OPW'(13);
    localparam logic [OPW-1:0] OC_RET   = OPW'(14);
    localparam logic [OPW-1:0] OC_PUSH  = OPW'(15);
    localparam logic [OPW-1:0] OC_POP   = OPW'(16);

    localparam step_t IDLE_S = '{op: A_NOP, a: S_REG, b: S_REG,
                                 last: 1'b0, ill: 1'b0};

    function automatic step_t dec(input logic [OPW-1:0] opc,
                                  input logic s);
        step_t r;
        r = '{op: A_NOP, a: S_REG, b: S_REG, last: 1'b1, ill: 1'b0};
        case (opc)
            OC_AND:  r.op = A_AND;
            OC_ANDI: begin r.op = A_AND; r.b = S_IMM; end
            OC_ADD:  r.op = A_ADD;
            OC_ADDI, OC_LW, OC_SW: begin
                r.op = A_ADD;
                r.b  = S_IMM;
            end
            OC_SUB:  r.op = A_SUB;
            OC_LWPOI: begin
                r.op   = A_ADD;
                r.b    = s ? S_ONE : S_IMM;
                r.last = s;
            end
            // Compare step, then optional PC+imm target step
            OC_BGT, OC_BLT, OC_BEQ, OC_BNE: begin
                if (s) begin
                    r.op = A_ADD;
                    r.a  = S_PC;
                    r.b  = S_IMM;
                end else begin
                    r.op   = A_SUB;
                    r.last = !BR_TARGET_ADD;
                end
            end
            OC_PUSH, OC_CALL: begin
                r.op = A_SUB; r.a = S_SP; r.b = S_ONE;
            end
            OC_POP, OC_RET: begin
                r.op = A_ADD; r.a = S_SP; r.b = S_ONE;
            end
            OC_JMP:  r.op = A_NOP;
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    state_t         state;
    step_t          cur;
    logic [OPW-1:0] op_q;
    logic           valid_q;
    logic           step_q;
    logic           rdy;

    assign rdy = (state == IDLE || cur.last) && !bus.stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cur     <= IDLE_S;
            op_q    <= '0;
            valid_q <= 1'b0;
            step_q  <= 1'b0;
        end else if (!bus.stall) begin
            if (bus.start && rdy) begin
                state   <= STEP0;
                op_q    <= bus.opcode;
                cur     <= dec(bus.opcode, 1'b0);
                valid_q <= 1'b1;
                step_q  <= 1'b0;
            end else if (state == STEP0 && !cur.last) begin
                state  <= STEP1;
                cur    <= dec(op_q, 1'b1);
                step_q <= 1'b1;
            end else begin
                state   <= IDLE;
                cur     <= IDLE_S;
                valid_q <= 1'b0;
                step_q  <= 1'b0;
            end
        end
    end

    assign bus.ready     = rdy;
    assign bus.alu_valid = valid_q;
    assign bus.alu_op    = cur.op;
    assign bus.src_a_sel = cur.a;
    assign bus.src_b_sel = cur.b;
    assign bus.alu_step  = step_q;
    assign bus.alu_last  = cur.last;
    assign bus.illegal   = cur.ill;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed scoreboard bench for alu_op_sequencer, with both
// branch-target configurations instantiated side by side.
module tb_alu_op_sequencer;

    typedef struct packed {
        logic       v;
        logic [1:0] op;
        logic [1:0] a;
        logic [1:0] b;
        logic       st;
        logic       last;
        logic       ill;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] opcode;
    logic       stall;
    int         tests = 0;
    int         fails = 0;
    exp_t       q1[$];
    exp_t       q0[$];

    alu_op_sequencer_if #(.OPW(6), .AOPW(2)) ia ();
    alu_op_sequencer_if #(.OPW(6), .AOPW(2)) ib ();

    assign ia.start  = start;
    assign ia.opcode = opcode;
    assign ia.stall  = stall;
    assign ib.start  = start;
    assign ib.opcode = opcode;
    assign ib.stall  = stall;

    alu_op_sequencer #(.BR_TARGET_ADD(1'b1)) dut (
        .clk(clk), .reset(reset), .bus(ia.slave)
    );

    alu_op_sequencer #(.BR_TARGET_ADD(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(ib.slave)
    );

    always #5 clk = ~clk;

    localparam exp_t IDL = '{v:0, op:3, a:0, b:0, st:0, last:0, ill:0};

    function automatic exp_t mk(input logic [1:0] op, input logic [1:0] a,
                                input logic [1:0] b, input logic st,
                                input logic last, input logic ill);
        return '{v:1'b1, op:op, a:a, b:b, st:st, last:last, ill:ill};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop1(input string tag);
        exp_t obs, e;
        obs = '{v: ia.alu_valid, op: ia.alu_op, a: ia.src_a_sel,
                b: ia.src_b_sel, st: ia.alu_step, last: ia.alu_last,
                ill: ia.illegal};
        tests++;
        if (q1.size() == 0) begin
            fails++;
            $error("FAIL %s: scoreboard empty, got %h", tag, obs);
        end else begin
            e = q1.pop_front();
            assert (obs === e) else begin
                fails++;
                $error("FAIL %s: got %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic pop0(input string tag);
        exp_t obs, e;
        obs = '{v: ib.alu_valid, op: ib.alu_op, a: ib.src_a_sel,
                b: ib.src_b_sel, st: ib.alu_step, last: ib.alu_last,
                ill: ib.illegal};
        tests++;
        if (q0.size() == 0) begin
            fails++;
            $error("FAIL %s: scoreboard empty, got %h", tag, obs);
        end else begin
            e = q0.pop_front();
            assert (obs === e) else begin
                fails++;
                $error("FAIL %s: got %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic chk_rdy(input string tag, input logic e);
        tests++;
        assert (ia.ready === e) else begin
            fails++;
            $error("FAIL %s: ready got %b expected %b", tag, ia.ready, e);
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        opcode = '0;
        stall  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        q1.push_back(IDL);
        pop1("reset_state");
        chk_rdy("reset_ready", 1'b1);

        // ADDI: one step ADD(RegA,imm)
        start = 1'b1; opcode = 6'd4;
        q1.push_back(mk(2'd1, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0));
        q1.push_back(IDL);
        tick();
        start = 1'b0;
        pop1("addi_step0");
        tick();
        pop1("addi_idle");

        // LWPOI with a 3-cycle stall in STEP0; opcode change must not leak
        start = 1'b1; opcode = 6'd6;
        repeat (4) q1.push_back(mk(2'd1, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0));
        q1.push_back(mk(2'd1, 2'd0, 2'd2, 1'b1, 1'b1, 1'b0));
        q1.push_back(IDL);
        tick();
        start = 1'b0; stall = 1'b1; opcode = 6'd2;
        pop1("lwpoi_s0");
        chk_rdy("lwpoi_s0_rdy", 1'b0);
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            tick();
            pop1("lwpoi_stall_hold");
            chk_rdy("lwpoi_stall_rdy", 1'b0);
        end
        start = 1'b0; stall = 1'b0;
        chk_rdy("lwpoi_s0_nostall_rdy", 1'b0);
        tick();
        pop1("lwpoi_s1");
        chk_rdy("lwpoi_s1_rdy", 1'b1);
        tick();
        pop1("lwpoi_idle");

        // BEQ in both branch-target configurations
        start = 1'b1; opcode = 6'd10;
        q1.push_back(mk(2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
        q1.push_back(mk(2'd1, 2'd1, 2'd1, 1'b1, 1'b1, 1'b0));
        q1.push_back(IDL);
        q0.push_back(mk(2'd2, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0));
        q0.push_back(IDL);
        tick();
        start = 1'b0;
        pop1("beq_br1_s0");
        pop0("beq_br0_s0");
        tick();
        pop1("beq_br1_s1");
        pop0("beq_br0_idle");
        tick();
        pop1("beq_br1_idle");

        // Back-to-back PUSH, POP, JMP with no bubble
        start = 1'b1; opcode = 6'd15;
        q1.push_back(mk(2'd2, 2'd2, 2'd2, 1'b0, 1'b1, 1'b0));
        q1.push_back(mk(2'd1, 2'd2, 2'd2, 1'b0, 1'b1, 1'b0));
        q1.push_back(mk(2'd3, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0));
        q1.push_back(IDL);
        tick();
        opcode = 6'd16;
        pop1("b2b_push");
        chk_rdy("b2b_push_rdy", 1'b1);
        tick();
        opcode = 6'd12;
        pop1("b2b_pop");
        tick();
        start = 1'b0;
        pop1("b2b_jmp");
        tick();
        pop1("b2b_idle");

        // Unknown opcode flags illegal on its single step
        start = 1'b1; opcode = 6'd63;
        q1.push_back(mk(2'd3, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1));
        q1.push_back(IDL);
        tick();
        start = 1'b0;
        pop1("illegal_step");
        tick();
        pop1("illegal_idle");

        // Reset during STEP0 of LWPOI drops STEP1
        start = 1'b1; opcode = 6'd6;
        q1.push_back(mk(2'd1, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0));
        q1.push_back(IDL);
        q1.push_back(IDL);
        tick();
        start = 1'b0;
        pop1("rst_mid_s0");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pop1("rst_mid_idle");
        chk_rdy("rst_mid_rdy", 1'b1);
        tick();
        pop1("rst_mid_no_s1");

        tests++;
        assert (q1.size() == 0 && q0.size() == 0) else begin
            fails++;
            $error("FAIL sb_drain: left %0d/%0d expected 0/0",
                   q1.size(), q0.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
